// File: rtl/delayfixed_fall_digital.sv
// Clocked falling-edge delay cell: rises pass after synchronisation, falls only after
// i has stayed low for DELAY_CYCLES consecutive samples; shorter lows are swallowed.
module delayfixed_fall_digital #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int DELAY_CYCLES  = 10,
    parameter int CNT_W         = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic CELCLK,
    input  logic CELRST,
    input  logic CELV,
    input  logic CELG,
    input  logic CELSUB,
    input  logic en,
    input  logic i,
    output logic o,
    output logic busy,
    output logic done
);

    generate
        if (DELAY_CYCLES < 2) begin : g_bad_delay_low
            $error("DELAY_CYCLES must be at least 2");
        end
        if (DELAY_CYCLES > (1 << CNT_W) - 1) begin : g_bad_delay_high
            $error("DELAY_CYCLES does not fit in CNT_W bits");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_HIGH  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int unused_period_ns = CLK_PERIOD_NS;

    // Supply, ground and substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ CELSUB;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   i_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = i;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign i_s = sync_reg[SYNC_STAGES-1];

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            sync_reg  <= '0;
            state_reg <= ST_LOW;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        if (!en) begin
            state_next = ST_LOW;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_LOW: begin
                    if (i_s) state_next = ST_HIGH;
                end
                ST_HIGH: begin
                    if (!i_s) begin
                        state_next = ST_COUNT;
                        cnt_next   = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    if (i_s) begin
                        // Low was too short: treat as a glitch and hold o high.
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so there is no path from i to o.
    always_comb begin
        o    = (state_reg != ST_LOW);
        busy = (state_reg == ST_COUNT);
        done = done_reg;
    end

endmodule

// File: tb/tb_delayfixed_fall_digital.sv
// Directed bench for delayfixed_fall_digital at default parameters: a per-edge vector
// table for reset and a full fall, plus hand sequences for glitch, boundary, enable and reset.
module tb_delayfixed_fall_digital;

    logic clk = 1'b0;
    logic rst, en, i;
    logic o, busy, done;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    delayfixed_fall_digital dut (
        .CELCLK (clk),
        .CELRST (rst),
        .CELV   (1'b1),
        .CELG   (1'b0),
        .CELSUB (1'b0),
        .en     (en),
        .i      (i),
        .o      (o),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic rst;
        logic en;
        logic i;
        logic o;
        logic busy;
        logic done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic x,
                       input logic eo, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.i = x; v.o = eo; v.busy = eb; v.done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive i=1, en=1 long enough that o is high and idle.
    task automatic settle(input string tag);
        rst = 1'b0; en = 1'b1; i = 1'b1;
        repeat (6) tick();
        check({tag, "_settle_o"}, o, 1'b1);
        check({tag, "_settle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int low_seen;

        rst = 1'b1; en = 1'b1; i = 1'b1;

        // Reset held 3 edges, then release with i=1: o rises after edge 3.
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        // Full fall: i=0 for 20 edges; busy after 3..11, o=0/done after 12.
        for (int n = 1; n <= 20; n++) begin
            if (n <= 2)       add(0, 1, 0, 1, 0, 0);
            else if (n <= 11) add(0, 1, 0, 1, 1, 0);
            else if (n == 12) add(0, 1, 0, 0, 0, 1);
            else              add(0, 1, 0, 0, 0, 0);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst; en = vecs[k].en; i = vecs[k].i;
            tick();
            $display("vec %0d: rst=%b en=%b i=%b -> o=%b busy=%b done=%b",
                     k, rst, en, i, o, busy, done);
            check($sformatf("vec%0d_o", k), o, vecs[k].o);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].busy);
            check($sformatf("vec%0d_done", k), done, vecs[k].done);
        end

        // Glitch: 5 low samples -> busy for 5 cycles, o stays high, no done.
        settle("glitch");
        busy_cnt = 0; done_cnt = 0; low_seen = 0;
        for (int n = 1; n <= 15; n++) begin
            i = (n <= 5) ? 1'b0 : 1'b1;
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (!o) low_seen++;
        end
        $display("glitch5: busy_cycles=%0d done_pulses=%0d o_low_cycles=%0d",
                 busy_cnt, done_cnt, low_seen);
        check("glitch_busy_cycles", (busy_cnt == 5), 1'b1);
        check("glitch_no_done", (done_cnt == 0), 1'b1);
        check("glitch_o_high", (low_seen == 0), 1'b1);

        // Boundary: 9 low samples never reach the output.
        settle("low9");
        done_cnt = 0; low_seen = 0;
        for (int n = 1; n <= 16; n++) begin
            i = (n <= 9) ? 1'b0 : 1'b1;
            tick();
            if (done) done_cnt++;
            if (!o) low_seen++;
        end
        $display("low9: done_pulses=%0d o_low_cycles=%0d", done_cnt, low_seen);
        check("low9_no_fall", (low_seen == 0), 1'b1);
        check("low9_no_done", (done_cnt == 0), 1'b1);

        // Boundary: 10 low samples -> o low only after edge 12, done pulses once.
        settle("low10");
        for (int n = 1; n <= 18; n++) begin
            i = (n <= 10) ? 1'b0 : 1'b1;
            tick();
            $display("low10 edge %0d: o=%b busy=%b done=%b", n, o, busy, done);
            check($sformatf("low10_e%0d_o", n), o, (n == 12) ? 1'b0 : 1'b1);
            check($sformatf("low10_e%0d_done", n), done, (n == 12) ? 1'b1 : 1'b0);
        end

        // Enable dropped at edge 7 of a fall.
        settle("en");
        i = 1'b0;
        repeat (6) tick();
        check("en_pre_busy", busy, 1'b1);
        en = 1'b0;
        tick();
        $display("en drop edge 7: o=%b busy=%b done=%b", o, busy, done);
        check("en_drop_o", o, 1'b0);
        check("en_drop_busy", busy, 1'b0);
        check("en_drop_done", done, 1'b0);
        i = 1'b1;
        done_cnt = 0; low_seen = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (done) done_cnt++;
            if (!o) low_seen++;
        end
        check("en_off_held_low", (low_seen == 5), 1'b1);
        check("en_off_no_done", (done_cnt == 0), 1'b1);
        en = 1'b1;
        tick();
        $display("en restore: o=%b busy=%b done=%b", o, busy, done);
        check("en_restore_o", o, 1'b1);

        // Reset asserted at edge 8 of a fall, then released with i=1.
        settle("rst");
        i = 1'b0;
        repeat (7) tick();
        check("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        $display("reset edge 8: o=%b busy=%b done=%b", o, busy, done);
        check("rst_mid_o", o, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        tick();
        rst = 1'b0; i = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            $display("post-reset edge %0d: o=%b done=%b", n, o, done);
            check($sformatf("rst_rel_e%0d_o", n), o, (n >= 3) ? 1'b1 : 1'b0);
            check($sformatf("rst_rel_e%0d_done", n), done, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
